// File: rtl/dec_ascii_streamer_pkg.sv
// dec_ascii_streamer_pkg: state encoding and character constants shared by the decimal streamer.
package dec_ascii_streamer_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, EMIT, TERM_CR, TERM_LF, DONE} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int DEC_BASE = 10;
endpackage

// File: rtl/dec_ascii_streamer_digit_stack.sv
// digit_stack: NDIG-entry 4-bit digit register file, one write port and one combinational read port.
module digit_stack #(
  parameter int NDIG = 3,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);
  logic [3:0] mem [NDIG];
  always_ff @(posedge clk or posedge reset)
    if (reset) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dec_ascii_streamer.sv
// dec_ascii_streamer: prints an unsigned value as decimal ASCII, MSD first, via repeated division by 10
// on an external shared divider, streaming bytes over a valid/ready TX handshake.
module dec_ascii_streamer
  import dec_ascii_streamer_pkg::*;
#(
  parameter int W = 8,
  parameter int NDIG = 3,
  parameter int TERM = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done_tick,
  output logic         div_start,
  output logic [W-1:0] div_dvnd,
  output logic [W-1:0] div_dvsr,
  input  logic [W-1:0] div_quo,
  input  logic [W-1:0] div_rmd,
  input  logic         div_ready,
  input  logic         div_done_tick,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(NDIG + 1);
  state_t state, state_n;
  logic [W-1:0] cur, cur_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] digit;
  logic xfer, last, unused_rmd;
  assign unused_rmd = ^div_rmd;
  assign xfer = tx_valid & tx_ready;
  assign last = (cnt + CW'(1)) == CW'(NDIG);
  digit_stack #(.NDIG(NDIG), .AW(IW)) u_digits (
    .clk(clk),
    .reset(reset),
    .we(state == CAPT),
    .waddr(cnt[IW-1:0]),
    .wdata(div_rmd[3:0]),
    .raddr(idx),
    .rdata(digit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      cnt <= '0;
      idx <= '0;
      tx_valid <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      cnt <= cnt_n;
      idx <= idx_n;
      tx_valid <= state_n inside {EMIT, TERM_CR, TERM_LF};
    end
  // Digits come out LSD first, so emission walks the stack back down from the top entry.
  always_comb begin
    state_n = state;
    cur_n = cur;
    cnt_n = cnt;
    idx_n = idx;
    case (state)
      IDLE: if (start) begin
        state_n = REQ;
        cur_n = value;
        cnt_n = '0;
      end
      REQ: if (div_ready) state_n = WAIT;
      WAIT: if (div_done_tick) state_n = CAPT;
      CAPT: begin
        cur_n = div_quo;
        cnt_n = cnt + CW'(1);
        state_n = (div_quo == '0 || last) ? EMIT : REQ;
        idx_n = (div_quo == '0 || last) ? cnt[IW-1:0] : idx;
      end
      EMIT: if (xfer) begin
        state_n = idx != '0 ? EMIT : TERM != 0 ? TERM_CR : DONE;
        idx_n = idx != '0 ? idx - IW'(1) : idx;
      end
      TERM_CR: if (xfer) state_n = TERM_LF;
      TERM_LF: if (xfer) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done_tick = state == DONE;
  assign div_start = state == REQ && div_ready;
  assign div_dvnd = cur;
  assign div_dvsr = W'(DEC_BASE);
  assign tx_data = state == EMIT ? ASCII_ZERO + {4'h0, digit} :
                   state == TERM_CR ? ASCII_CR :
                   state == TERM_LF ? ASCII_LF : 8'h00;
endmodule

// File: tb/tb_dec_ascii_streamer.sv
// tb_dec_ascii_streamer: directed checks of the streamer with TERM=0 (dut 0) and TERM=1 (dut 1),
// each on its own behavioural divider whose remainder is junk during done_tick.
module tb_dec_ascii_streamer;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] start = '0, tx_ready = 2'b11;
  logic [1:0] busy, done_tick, div_start, div_ready, div_done_tick, tx_valid;
  logic [7:0] value [2] = '{8'd0, 8'd0};
  logic [7:0] div_dvnd [2], div_dvsr [2], div_quo [2], div_rmd [2], tx_data [2];
  logic [7:0] dhold [2], pd [2];
  int dcnt [2];
  logic [7:0] txl [2][16], dvl [2][16];
  int txn [2] = '{0, 0}, dvn [2] = '{0, 0}, ndone [2] = '{0, 0}, done_at [2] = '{0, 0}, stall_err [2] = '{0, 0};
  logic [1:0] stalled = '0;
  int bt [2], bd [2], bn [2];
  int n_assert = 0, n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dec_ascii_streamer #(.W(8), .NDIG(3), .TERM(g)) dut (
      .clk(clk), .reset(reset), .start(start[g]), .value(value[g]),
      .busy(busy[g]), .done_tick(done_tick[g]),
      .div_start(div_start[g]), .div_dvnd(div_dvnd[g]), .div_dvsr(div_dvsr[g]),
      .div_quo(div_quo[g]), .div_rmd(div_rmd[g]), .div_ready(div_ready[g]),
      .div_done_tick(div_done_tick[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g])
    );
  end

  always_comb for (int i = 0; i < 2; i++) div_ready[i] = dcnt[i] == 0;

  always @(posedge clk or posedge reset)
    for (int i = 0; i < 2; i++)
      if (reset) begin
        dcnt[i] <= 0;
        dhold[i] <= '0;
        div_done_tick[i] <= 1'b0;
        div_quo[i] <= '0;
        div_rmd[i] <= '0;
      end else begin
        div_done_tick[i] <= dcnt[i] == 2;
        if (dcnt[i] == 2) begin
          div_quo[i] <= 8'hEE;
          div_rmd[i] <= 8'hEE;
        end
        if (dcnt[i] == 1) begin
          div_quo[i] <= dhold[i] / 8'd10;
          div_rmd[i] <= dhold[i] % 8'd10;
        end
        if (div_start[i] && dcnt[i] == 0) begin
          dcnt[i] <= 3;
          dhold[i] <= div_dvnd[i];
        end else if (dcnt[i] != 0) dcnt[i] <= dcnt[i] - 1;
      end

  always @(negedge clk)
    if (!reset)
      for (int i = 0; i < 2; i++) begin
        if (div_start[i]) begin
          dvl[i][dvn[i] % 16] <= div_dvnd[i];
          dvn[i] <= dvn[i] + 1;
        end
        if (tx_valid[i] && tx_ready[i]) begin
          txl[i][txn[i] % 16] <= tx_data[i];
          txn[i] <= txn[i] + 1;
        end
        if (done_tick[i]) begin
          ndone[i] <= ndone[i] + 1;
          done_at[i] <= txn[i];
        end
        if (stalled[i] && !(tx_valid[i] && tx_data[i] == pd[i])) stall_err[i] <= stall_err[i] + 1;
        stalled[i] <= tx_valid[i] && !tx_ready[i];
        pd[i] <= tx_data[i];
      end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int i, input logic [7:0] v);
    bt[i] = txn[i];
    bd[i] = dvn[i];
    bn[i] = ndone[i];
    value[i] = v;
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 400 && ndone[i] == bn[i]; c++) tick(1);
    chk("done_count", ndone[i] - bn[i], 1);
    chk("busy_after", int'(busy[i]), 0);
  endtask

  task automatic chk_run(input int i, input int nb, input logic [7:0] eb [4], input int nd, input logic [7:0] ed [3]);
    chk("byte_count", txn[i] - bt[i], nb);
    for (int k = 0; k < nb; k++) chk($sformatf("byte%0d", k), int'(txl[i][(bt[i] + k) % 16]), int'(eb[k]));
    chk("div_count", dvn[i] - bd[i], nd);
    for (int k = 0; k < nd; k++) chk($sformatf("dvnd%0d", k), int'(dvl[i][(bd[i] + k) % 16]), int'(ed[k]));
    chk("done_after_bytes", done_at[i] - bt[i], nb);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy[0]), 0);
    chk({tag, "_done"}, int'(done_tick[0]), 0);
    chk({tag, "_div_start"}, int'(div_start[0]), 0);
    chk({tag, "_dvnd"}, int'(div_dvnd[0]), 0);
    chk({tag, "_tx_valid"}, int'(tx_valid[0]), 0);
    chk({tag, "_tx_data"}, int'(tx_data[0]), 0);
  endtask

  initial begin
    tick(2);
    chk_idle("in_reset");
    reset = 1'b0;
    tick(1);
    chk_idle("post_reset");

    go(0, 8'd0);
    chk("dvsr", int'(div_dvsr[0]), 10);
    wait_done(0);
    chk_run(0, 1, '{8'h30, 8'h00, 8'h00, 8'h00}, 1, '{8'd0, 8'd0, 8'd0});

    go(0, 8'd255);
    wait_done(0);
    chk_run(0, 3, '{8'h32, 8'h35, 8'h35, 8'h00}, 3, '{8'd255, 8'd25, 8'd2});

    go(0, 8'd7);
    wait_done(0);
    chk_run(0, 1, '{8'h37, 8'h00, 8'h00, 8'h00}, 1, '{8'd7, 8'd0, 8'd0});

    tx_ready[0] = 1'b0;
    go(0, 8'd128);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 100 && !tx_valid[0]; c++) tick(1);
      tick(5);
      chk($sformatf("stall_valid%0d", k), int'(tx_valid[0]), 1);
      chk($sformatf("stall_data%0d", k), int'(tx_data[0]), k == 0 ? 'h31 : k == 1 ? 'h32 : 'h38);
      tx_ready[0] = 1'b1;
      tick(1);
      tx_ready[0] = 1'b0;
    end
    wait_done(0);
    tx_ready[0] = 1'b1;
    chk("stall_hold_errors", stall_err[0], 0);
    chk_run(0, 3, '{8'h31, 8'h32, 8'h38, 8'h00}, 3, '{8'd128, 8'd12, 8'd1});

    go(1, 8'd42);
    wait_done(1);
    chk_run(1, 4, '{8'h34, 8'h32, 8'h0D, 8'h0A}, 2, '{8'd42, 8'd4, 8'd0});

    go(0, 8'd200);
    for (int c = 0; c < 20 && !div_start[0]; c++) tick(1);
    tick(1);
    chk("in_wait_busy", int'(busy[0]), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_idle("after_abort");
    tick(20);
    chk("abort_no_bytes", txn[0] - bt[0], 0);
    chk("abort_no_done", ndone[0] - bn[0], 0);
    chk_idle("abort_settled");

    go(0, 8'd100);
    tick(3);
    value[0] = 8'd5;
    start[0] = 1'b1;
    tick(2);
    start[0] = 1'b0;
    wait_done(0);
    chk_run(0, 3, '{8'h31, 8'h30, 8'h30, 8'h00}, 3, '{8'd100, 8'd10, 8'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dec_ascii_streamer.md
Name: dec_ascii_streamer

Overview:
Converts a W-bit unsigned binary value into decimal ASCII characters and streams them, most significant digit first, to the UART transmit path.
It sits between the banner/message source and the UART TX byte interface. It feeds the shared sequential divider through that divider's start/ready/done_tick handshake, using repeated division by 10, and consumes the quotient and remainder it produces.
The divider is external: this block drives its ports but does not instantiate it.

Parameters:
W, 8, operand width; must match the divider width; W >= 4.
NDIG, 3, digit buffer depth; must satisfy 10^NDIG > 2^W - 1.
TERM, 0, 1 = append CR (0x0D) and LF (0x0A) after the last digit; 0 = digits only.

Ports:
clk  in  1  clock; all state changes on its rising edge.
reset  in  1  reset, asynchronous, active-high.
start  in  1  request conversion of value; accepted only in IDLE.
value  in  W  unsigned number to print; captured on the accepted start.
busy  out  1  high in every state except IDLE.
done_tick  out  1  one-cycle pulse after the final character is accepted.
div_start  out  1  one-cycle start pulse to the divider.
div_dvnd  out  W  dividend to the divider.
div_dvsr  out  W  divisor to the divider; constant 10.
div_quo  in  W  divider quotient.
div_rmd  in  W  divider remainder.
div_ready  in  1  divider is idle and can accept a start.
div_done_tick  in  1  divider completion pulse.
tx_data  out  8  ASCII byte to the UART TX.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  UART TX accepts the byte.

Behaviour:
- Reset values: all outputs 0; internal value, digit count and emit index 0; state IDLE. The state is forced to IDLE from any state, with no partial output afterwards.
- States:
  - IDLE: on start, capture cur = value, cnt = 0, go to REQ. A start in any other state is ignored.
  - REQ: wait for div_ready. When it is high, pulse div_start for exactly 1 cycle with div_dvnd = cur, then go to WAIT. div_dvnd holds cur at all times.
  - WAIT: on div_done_tick, go to CAPT. The divider remainder is not final until the cycle after its done_tick.
  - CAPT: store digit[cnt] = div_rmd[3:0], set cur = div_quo, cnt += 1.
    - If div_quo == 0 or cnt+1 == NDIG: go to EMIT with idx = cnt (the new count minus 1).
    - Otherwise go back to REQ.
  - EMIT: tx_valid = 1, tx_data = 0x30 + digit[idx].
    - A transfer occurs in a cycle where tx_valid and tx_ready are both high.
    - On transfer at idx == 0: go to TERM_CR if TERM = 1, else DONE. Otherwise idx -= 1.
  - TERM_CR: present 0x0D; on transfer go to TERM_LF.
  - TERM_LF: present 0x0A; on transfer go to DONE.
  - DONE: done_tick = 1 for one cycle, then IDLE.
- tx_valid is registered. While tx_valid is high and tx_ready is low, tx_data is held stable. tx_valid never drops without a transfer, except on reset.
- value = 0 performs exactly one division and emits the single character "0". Leading zeros are never emitted.
- If the NDIG limit stops the loop while the quotient is nonzero (an illegal parameter choice), the upper digits are dropped and the low NDIG digits are emitted.
- Latency per digit: at least 1 (REQ) + divider time + 1 (CAPT) cycles. Emission is one byte per cycle when tx_ready is held high.
- The back-to-back tx handshake gives full throughput: in EMIT the next byte is presented in the cycle after a transfer.
- A div_done_tick outside WAIT is ignored.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, REQ, WAIT, CAPT, EMIT, TERM_CR, TERM_LF, DONE)
  - ASCII_ZERO = 8'h30, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
  - DEC_BASE = 10
- One sub-module: digit_stack. It is an NDIG-entry, 4-bit register file with a write port (addr, data, we) and a combinational read port (addr), reset to 0.
- The FSM, counters and the tx/divider handshakes stay in dec_ascii_streamer.

Test Plan:
- W=8, TERM=0, value=0, tx_ready=1 -> exactly 1 div_start with dvnd=0; tx bytes 0x30; one done_tick; busy returns to 0.
- value=255 -> div_start pulses with dvnd 255, 25, 2; tx bytes 0x32, 0x35, 0x35 in that order; done_tick after the third transfer.
- value=7 -> single division; single byte 0x37.
- value=128, tx_ready held low 5 cycles at each byte -> tx_valid stays high and tx_data stays stable through each stall; bytes 0x31, 0x32, 0x38.
- TERM=1, value=42 -> bytes 0x34, 0x32, 0x0D, 0x0A, then done_tick.
- Reset asserted during WAIT of value=200 -> the cycle after reset, all outputs are 0 and the state is IDLE; no byte is emitted. Then start with value=100 -> bytes 0x31, 0x30, 0x30. A start asserted while busy is ignored.
